// File: rtl/motor_step_scheduler_pkg.sv
// rtl/motor_step_scheduler_pkg.sv - shared constants and state encoding for the step scheduler
package motor_step_scheduler_pkg;

  localparam int NUM_MOTORS_DEF = 6;
  localparam int POS_W_DEF      = 10;

  // Largest legal value of a single BCD digit
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_COMPARE   = 3'd2;
  localparam state_t ST_STEP_HIGH = 3'd3;
  localparam state_t ST_STEP_LOW  = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

endpackage

// File: rtl/motor_step_scheduler_bcd3_to_bin.sv
// rtl/motor_step_scheduler_bcd3_to_bin.sv - three BCD digits to binary with a digit-valid flag
module bcd3_to_bin
  import motor_step_scheduler_pkg::*;
#(
  parameter int POS_W = POS_W_DEF
) (
  input  logic [3:0]       digit_h,
  input  logic [3:0]       digit_t,
  input  logic [3:0]       digit_o,
  output logic [POS_W-1:0] bin,
  output logic             digits_ok
);

  // Wide enough for the worst illegal input (15*100+15*10+15) so the sum never wraps
  logic [13:0] sum;

  // Weighted sum of the digits; value is only meaningful when digits_ok is set
  always_comb begin
    sum       = 14'(digit_h) * 14'd100 + 14'(digit_t) * 14'd10 + 14'(digit_o);
    bin       = sum[POS_W-1:0];
    digits_ok = (digit_h <= BCD_DIGIT_MAX) && (digit_t <= BCD_DIGIT_MAX) &&
                (digit_o <= BCD_DIGIT_MAX);
  end

endmodule

// File: rtl/motor_step_scheduler.sv
// rtl/motor_step_scheduler.sv - moves one of six steppers to a BCD target and tracks positions
module motor_step_scheduler
  import motor_step_scheduler_pkg::*;
#(
  parameter int NUM_MOTORS = NUM_MOTORS_DEF,
  parameter int POS_W      = POS_W_DEF,
  parameter int STEP_DIV   = 25000
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  INIT,
  input  logic                  cmd_valid,
  input  logic [NUM_MOTORS-1:0] Motor,
  input  logic [3:0]            TValue0,
  input  logic [3:0]            TValue1,
  input  logic [3:0]            TValue2,
  output logic [NUM_MOTORS-1:0] step,
  output logic                  dir,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [POS_W-1:0]      cur_pos
);

  localparam int IDX_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int CNT_W = $clog2(STEP_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [POS_W-1:0]        target_q, target_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dir_q, dir_d;
  logic [POS_W-1:0]        cur_pos_q, cur_pos_d;
  logic [POS_W-1:0]        pos_q [NUM_MOTORS];
  logic [POS_W-1:0]        pos_d [NUM_MOTORS];
  logic [NUM_MOTORS-1:0]   step_q, step_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [POS_W-1:0]        tgt_bin;
  logic                    digits_ok;
  logic                    motor_ok;
  logic [IDX_W-1:0]        sel_idx;
  logic [POS_W-1:0]        pos_sel;
  logic [POS_W-1:0]        pos_next;

  bcd3_to_bin #(.POS_W(POS_W)) u_bcd (
    .digit_h   (TValue0),
    .digit_t   (TValue1),
    .digit_o   (TValue2),
    .bin       (tgt_bin),
    .digits_ok (digits_ok)
  );

  // One-hot check and encode of the motor select
  always_comb begin
    motor_ok = (Motor != '0) && ((Motor & (Motor - NUM_MOTORS'(1))) == '0);
    sel_idx  = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (Motor[i]) sel_idx = IDX_W'(i);
    end
  end

  // Position of the active motor and its neighbour one step toward the target
  always_comb begin
    pos_sel  = pos_q[idx_q];
    pos_next = dir_q ? (pos_sel + POS_W'(1)) : (pos_sel - POS_W'(1));
  end

  // Move sequencer: command accept, compare, pulse timing and position bookkeeping
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    cur_pos_d = cur_pos_q;
    pos_d     = pos_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (motor_ok && digits_ok) begin
            idx_d    = sel_idx;
            target_d = tgt_bin;
            state_d  = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        cur_pos_d = pos_sel;
        state_d   = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (target_q == pos_sel) begin
          state_d = ST_DONE;
        end else begin
          dir_d   = (target_q > pos_sel);
          cnt_d   = '0;
          state_d = ST_STEP_HIGH;
        end
      end
      ST_STEP_HIGH: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_STEP_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STEP_LOW: begin
        if (cnt_q == CNT_LAST) begin
          pos_d[idx_q] = pos_next;
          cur_pos_d    = pos_next;
          cnt_d        = '0;
          state_d      = ST_COMPARE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (INIT) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      target_d  = '0;
      cnt_d     = '0;
      dir_d     = 1'b0;
      cur_pos_d = '0;
      err_d     = 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) pos_d[i] = '0;
    end
  end

  // Registered status outputs, one cycle behind the state that produces them
  always_comb begin
    step_d = '0;
    if (state_q == ST_STEP_HIGH) step_d[idx_q] = 1'b1;
    busy_d = (state_q == ST_LOAD) || (state_q == ST_COMPARE) ||
             (state_q == ST_STEP_HIGH) || (state_q == ST_STEP_LOW);
    done_d = (state_q == ST_DONE);
    if (INIT) begin
      step_d = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      cur_pos_q <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) pos_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      cur_pos_q <= cur_pos_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_MOTORS; i++) pos_q[i] <= pos_d[i];
    end
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign cur_pos = cur_pos_q;

endmodule
